// File: rtl/wormhole_xbar_out_port_if.sv
// Handshake bundle between the crossbar output port, its NUM_IN input buffers and the output link.
interface wormhole_xbar_out_port_if #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 8
);
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_ready;
  logic [NUM_IN-1:0]        out_grant;
  logic                     err_proto;

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_flit, out_grant, err_proto
  );

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_flit, out_grant, err_proto
  );
endinterface

// File: rtl/wormhole_xbar_out_port.sv
// Crossbar output port: round-robin arbitration among NUM_IN input buffers, wormhole lock
// from head to tail, and a registered valid/ready output stage.
module wormhole_xbar_out_port #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  wormhole_xbar_out_port_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {FT_SINGLE = 2'b00, FT_HEAD = 2'b01, FT_BODY = 2'b10, FT_TAIL = 2'b11} flit_type_e;
  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e             r_state;
  logic [IDX_W-1:0]   r_lock;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_out_valid;
  logic [FLIT_W-1:0]  r_out_flit;
  logic [NUM_IN-1:0]  r_out_grant;
  logic               r_err_proto;
  logic               r_idle_stray;

  logic               w_load_en;
  logic [NUM_IN-1:0]  w_cand;
  logic [NUM_IN-1:0]  w_stray;
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [FLIT_W-1:0]  w_sel_flit;
  flit_type_e         w_sel_type;
  logic               w_xfer;
  logic               w_stray_alone;
  logic [NUM_IN-1:0]  w_in_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    // Gating with rst_n keeps the buffers from being popped while the port is held in reset.
    w_load_en   = rst_n && (!r_out_valid || bus.out_ready);
    w_cand      = '0;
    w_stray     = '0;
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_cand[i]  = bus.in_valid[i] && !bus.in_flit[i*FLIT_W + FLIT_W-1];
      w_stray[i] = bus.in_valid[i] &&  bus.in_flit[i*FLIT_W + FLIT_W-1];
    end
    if (r_state == S_IDLE) begin
      // Scan from the far end back so the nearest candidate after rr_ptr is written last.
      for (int k = NUM_IN; k >= 1; k--) begin
        if (w_cand[(int'(r_rr_ptr) + k) % NUM_IN]) begin
          w_sel_valid = 1'b1;
          w_sel_idx   = IDX_W'((int'(r_rr_ptr) + k) % NUM_IN);
        end
      end
    end else begin
      w_sel_valid = bus.in_valid[r_lock];
      w_sel_idx   = r_lock;
    end
    w_sel_flit    = bus.in_flit[int'(w_sel_idx)*FLIT_W +: FLIT_W];
    w_sel_type    = flit_type_e'(w_sel_flit[FLIT_W-1 -: 2]);
    w_xfer        = w_sel_valid && w_load_en;
    w_in_ready    = w_xfer ? (NUM_IN'(1) << w_sel_idx) : '0;
    w_stray_alone = (r_state == S_IDLE) && (w_cand == '0) && (w_stray != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lock       <= '0;
      r_rr_ptr     <= IDX_W'(NUM_IN-1);
      r_out_valid  <= 1'b0;
      r_out_flit   <= '0;
      r_out_grant  <= '0;
      r_err_proto  <= 1'b0;
      r_idle_stray <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_flit  <= w_sel_flit;
        r_out_valid <= 1'b1;
      end else if (w_load_en) begin
        r_out_valid <= 1'b0;
      end

      // A body/tail with nobody to follow is tolerated for one cycle, flagged on the second.
      r_idle_stray <= w_stray_alone;
      if (w_stray_alone && r_idle_stray) r_err_proto <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_sel_type == FT_HEAD) begin
              r_state     <= S_LOCKED;
              r_lock      <= w_sel_idx;
              r_out_grant <= NUM_IN'(1) << w_sel_idx;
            end else begin
              r_rr_ptr <= w_sel_idx;
            end
          end
        end
        S_LOCKED: begin
          if (w_xfer) begin
            if (w_sel_type == FT_HEAD || w_sel_type == FT_SINGLE) r_err_proto <= 1'b1;
            // A single inside a packet closes it like a tail; a stray head continues it like a body.
            if (w_sel_type == FT_TAIL || w_sel_type == FT_SINGLE) begin
              r_state     <= S_IDLE;
              r_rr_ptr    <= r_lock;
              r_out_grant <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_flit  = r_out_flit;
  assign bus.out_grant = r_out_grant;
  assign bus.err_proto = r_err_proto;
endmodule
